// File: rtl/divisor_secuencial_param.sv
// Parametrised sequential restoring divider: one quotient bit per clock, with remainder,
// divide-by-zero and signed-overflow flags, and an optional truncating signed mode.
module divisor_secuencial_param #(
  parameter int DD_W      = 32,
  parameter int DV_W      = 16,
  parameter bit SIGNED_EN = 1
) (
  input  logic            reloj,
  input  logic            reset,
  input  logic            inicie,
  input  logic [DD_W-1:0] dividendo,
  input  logic [DV_W-1:0] divisor,
  input  logic            con_signo,
  output logic [DD_W-1:0] cociente,
  output logic [DV_W-1:0] residuo,
  output logic            termino,
  output logic            div_cero,
  output logic            desborde
);

  localparam int CW = $clog2(DD_W);
  localparam logic [CW-1:0] LAST = CW'(DD_W - 1);

  typedef enum logic [1:0] {REPOSO, CALCULO, CERO} state_t;

  state_t state, state_next;

  logic            inicie_q;
  logic            start;
  logic            signed_op;
  logic            dd_neg;
  logic            dv_neg;
  logic            dv_zero;
  logic            is_ovf;
  logic [DD_W-1:0] dd_mag;
  logic [DV_W-1:0] dv_mag;

  logic [DD_W-1:0] shift;
  logic [DV_W-1:0] rem;
  logic [DV_W-1:0] dv_q;
  logic [CW-1:0]   cnt;
  logic            neg_q;
  logic            neg_r;
  logic            ovf_q;

  logic [DV_W-1:0] trial_lo;
  logic            fits;
  logic [DV_W-1:0] rem_next;
  logic [DD_W-1:0] shift_next;
  logic [DD_W-1:0] q_final;
  logic [DV_W-1:0] r_final;

  assign start = inicie & ~inicie_q & (state == REPOSO);

  always_comb begin
    signed_op = SIGNED_EN && con_signo;
    dd_neg    = signed_op & dividendo[DD_W-1];
    dv_neg    = signed_op & divisor[DV_W-1];
    dd_mag    = dd_neg ? -dividendo : dividendo;
    dv_mag    = dv_neg ? -divisor : divisor;
    dv_zero   = (divisor == '0);
    is_ovf    = signed_op && (dividendo == {1'b1, {(DD_W-1){1'b0}}}) && (divisor == '1);
  end

  // The DV_W+1 bit partial remainder is {rem msb, trial_lo}; a set msb always exceeds the divisor.
  always_comb begin
    trial_lo   = {rem[DV_W-2:0], shift[DD_W-1]};
    fits       = rem[DV_W-1] | (trial_lo >= dv_q);
    rem_next   = fits ? (trial_lo - dv_q) : trial_lo;
    shift_next = {shift[DD_W-2:0], fits};
    q_final    = neg_q ? -shift_next : shift_next;
    r_final    = neg_r ? -rem_next : rem_next;
  end

  always_ff @(posedge reloj) begin
    if (reset) state <= REPOSO;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    termino    = 1'b0;
    case (state)
      REPOSO: begin
        termino = 1'b1;
        if (start) begin
          if (dv_zero) state_next = CERO;
          else         state_next = CALCULO;
        end
      end
      CALCULO: begin
        if (cnt == LAST) state_next = REPOSO;
      end
      CERO:    state_next = REPOSO;
      default: state_next = REPOSO;
    endcase
  end

  // On a zero divisor the shift register keeps the raw dividend so CERO can return its low bits.
  always_ff @(posedge reloj) begin
    if (reset) begin
      inicie_q <= 1'b0;
      cociente <= '0;
      residuo  <= '0;
      div_cero <= 1'b0;
      desborde <= 1'b0;
      shift    <= '0;
      rem      <= '0;
      dv_q     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      inicie_q <= inicie;
      case (state)
        REPOSO: begin
          if (start) begin
            div_cero <= 1'b0;
            desborde <= 1'b0;
            dv_q     <= dv_mag;
            rem      <= '0;
            cnt      <= '0;
            neg_q    <= dd_neg ^ dv_neg;
            neg_r    <= dd_neg;
            ovf_q    <= is_ovf;
            shift    <= dv_zero ? dividendo : dd_mag;
          end
        end
        CALCULO: begin
          shift <= shift_next;
          rem   <= rem_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cociente <= q_final;
            residuo  <= r_final;
            desborde <= ovf_q;
          end
        end
        CERO: begin
          cociente <= '1;
          residuo  <= shift[DV_W-1:0];
          div_cero <= 1'b1;
          desborde <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial_param.sv
// Self-checking bench for divisor_secuencial_param: directed and random divides on a 32/16
// instance and an 8/4 instance, compared against plain signed/unsigned arithmetic.
module tb_divisor_secuencial_param;

  logic reloj = 1'b0;
  always #5 reloj = ~reloj;

  logic        reset;
  logic        inicie;
  logic [31:0] dividendo;
  logic [15:0] divisor;
  logic        con_signo;
  logic [31:0] cociente;
  logic [15:0] residuo;
  logic        termino;
  logic        div_cero;
  logic        desborde;

  logic       s_inicie;
  logic [7:0] s_dividendo;
  logic [3:0] s_divisor;
  logic       s_con_signo;
  logic [7:0] s_cociente;
  logic [3:0] s_residuo;
  logic       s_termino;
  logic       s_div_cero;
  logic       s_desborde;

  int checks = 0;
  int errors = 0;

  divisor_secuencial_param #(.DD_W(32), .DV_W(16), .SIGNED_EN(1)) dut (
    .reloj(reloj), .reset(reset), .inicie(inicie), .dividendo(dividendo),
    .divisor(divisor), .con_signo(con_signo), .cociente(cociente), .residuo(residuo),
    .termino(termino), .div_cero(div_cero), .desborde(desborde)
  );

  divisor_secuencial_param #(.DD_W(8), .DV_W(4), .SIGNED_EN(1)) dut_small (
    .reloj(reloj), .reset(reset), .inicie(s_inicie), .dividendo(s_dividendo),
    .divisor(s_divisor), .con_signo(s_con_signo), .cociente(s_cociente), .residuo(s_residuo),
    .termino(s_termino), .div_cero(s_div_cero), .desborde(s_desborde)
  );

  // Reference: signed results come from the language's truncating / and %.
  function automatic void refModel(input int ddw, input int dvw, input longint dd, input longint dv,
                                   input bit sgn, output longint q, output longint r,
                                   output bit dz, output bit ov);
    longint one, mdd, mdv, sdd, sdv;
    one = 1;
    mdd = (one << ddw) - 1;
    mdv = (one << dvw) - 1;
    dz  = 1'b0;
    ov  = 1'b0;
    if (dv == 0) begin
      q  = mdd;
      r  = dd & mdv;
      dz = 1'b1;
    end else if (!sgn) begin
      q = dd / dv;
      r = dd % dv;
    end else begin
      sdd = dd[ddw-1] ? dd - (one << ddw) : dd;
      sdv = dv[dvw-1] ? dv - (one << dvw) : dv;
      if (sdd == -(one << (ddw - 1)) && sdv == -1) begin
        q  = one << (ddw - 1);
        r  = 0;
        ov = 1'b1;
      end else begin
        q = (sdd / sdv) & mdd;
        r = (sdd % sdv) & mdv;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] dd, input logic [15:0] dv, input bit sgn,
                               input bit glitch);
    longint q, r;
    bit     dz, ov;
    int     busy;
    refModel(32, 16, longint'(dd), longint'(dv), sgn, q, r, dz, ov);
    @(negedge reloj);
    dividendo = dd;
    divisor   = dv;
    con_signo = sgn;
    inicie    = 1'b1;
    busy      = 0;
    do begin
      @(negedge reloj);
      if (!termino) busy++;
      if (busy == 3) begin
        dividendo = $urandom;
        divisor   = 16'($urandom);
        con_signo = ~sgn;
      end
      if (glitch && busy == 5) inicie = 1'b0;
      if (glitch && busy == 6) inicie = 1'b1;
    end while (!termino && busy < 100);
    checkOutput("latency", busy, (dv == 0) ? 1 : 32);
    checkOutput("cociente", cociente, q);
    checkOutput("residuo", residuo, r);
    checkOutput("div_cero", div_cero, dz);
    checkOutput("desborde", desborde, ov);
    repeat (3) begin
      @(negedge reloj);
      checkOutput("hold_idle", termino, 1);
    end
    inicie = 1'b0;
  endtask

  task automatic applySmall(input logic [7:0] dd, input logic [3:0] dv, input bit sgn,
                            input bit glitch);
    longint q, r;
    bit     dz, ov;
    int     busy;
    refModel(8, 4, longint'(dd), longint'(dv), sgn, q, r, dz, ov);
    @(negedge reloj);
    s_dividendo = dd;
    s_divisor   = dv;
    s_con_signo = sgn;
    s_inicie    = 1'b1;
    busy        = 0;
    do begin
      @(negedge reloj);
      if (!s_termino) busy++;
      if (glitch && busy == 3) s_inicie = 1'b0;
      if (glitch && busy == 4) s_inicie = 1'b1;
    end while (!s_termino && busy < 100);
    checkOutput("s_latency", busy, (dv == 0) ? 1 : 8);
    checkOutput("s_cociente", s_cociente, q);
    checkOutput("s_residuo", s_residuo, r);
    checkOutput("s_div_cero", s_div_cero, dz);
    checkOutput("s_desborde", s_desborde, ov);
    @(negedge reloj);
    checkOutput("s_hold_idle", s_termino, 1);
    s_inicie = 1'b0;
  endtask

  initial begin
    logic [31:0] rdd;
    logic [15:0] rdv;
    int          sel;

    reset       = 1'b1;
    inicie      = 1'b0;
    dividendo   = '0;
    divisor     = '0;
    con_signo   = 1'b0;
    s_inicie    = 1'b0;
    s_dividendo = '0;
    s_divisor   = '0;
    s_con_signo = 1'b0;
    repeat (2) @(negedge reloj);
    checkOutput("rst_termino", termino, 1);
    checkOutput("rst_cociente", cociente, 0);
    checkOutput("rst_residuo", residuo, 0);
    checkOutput("rst_div_cero", div_cero, 0);
    checkOutput("rst_desborde", desborde, 0);
    reset = 1'b0;

    $display("[TB] directed unsigned, zero and signed cases");
    applyStimulus(32'h352, 16'h3, 1'b0, 1'b0);
    applyStimulus(32'd1024, 16'h20, 1'b0, 1'b0);
    applyStimulus(32'd77, 16'h0, 1'b0, 1'b0);
    applyStimulus(32'd100, 16'd7, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFF9, 16'd2, 1'b1, 1'b0);
    applyStimulus(32'h8000_0000, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(32'h8000_0000, 16'h0001, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 16'hFFFF, 1'b0, 1'b0);

    $display("[TB] reset in the middle of an operation");
    @(negedge reloj);
    dividendo = 32'd987654;
    divisor   = 16'd321;
    con_signo = 1'b0;
    inicie    = 1'b1;
    repeat (11) @(negedge reloj);
    reset  = 1'b1;
    inicie = 1'b0;
    @(negedge reloj);
    checkOutput("midrst_termino", termino, 1);
    checkOutput("midrst_cociente", cociente, 0);
    checkOutput("midrst_residuo", residuo, 0);
    checkOutput("midrst_div_cero", div_cero, 0);
    checkOutput("midrst_desborde", desborde, 0);
    reset = 1'b0;
    applyStimulus(32'd987654, 16'd321, 1'b0, 1'b0);

    $display("[TB] restart attempt during computation");
    applyStimulus(32'd500000, 16'd77, 1'b0, 1'b1);

    $display("[TB] random 32/16 operations");
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 7);
      rdd = $urandom;
      rdv = 16'($urandom);
      if (sel == 0) rdv = '0;
      if (sel == 1) rdv = 16'hFFFF;
      if (sel == 2) rdv = 16'($urandom_range(1, 9));
      applyStimulus(rdd, rdv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] 8/4 instance");
    applySmall(8'd200, 4'd7, 1'b0, 1'b1);
    applySmall(8'h80, 4'hF, 1'b1, 1'b0);
    applySmall(8'd13, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applySmall(8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
